issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 The block SHALL have the following ports, one clock domain, with the clock and reset listed first:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a decoded instruction.
- id_rs  in  5  source register 1 number.
- id_rt  in  5  source register 2 number.
- id_read_type  in  2  bit0 = reads rs, bit1 = reads rt.
- id_wen  in  1  instruction writes a GPR.
- id_wnum  in  5  destination GPR number.
- id_div  in  1  instruction starts a divide and writes HI/LO.
- id_hilo_rd  in  1  instruction reads HI/LO (MFHI/MFLO).
- wb_wen  in  1  WB stage retires a GPR write this cycle.
- wb_wnum  in  5  GPR written by WB.
- flush  in  1  pipeline flush (exception/eret).
- id_ready  out  1  ID instruction may issue.
- id_issue  out  1  id_valid && id_ready.
- div_busy  out  1  divider FSM not IDLE.
- div_done  out  1  one-cycle pulse when the divide result is valid.
- sb_err  out  1  sticky; WB retired a register with zero pending count.

Function
REQ-002 The block SHALL keep a 2-bit pending counter pend[r] for each r in 1..31; r = 0 SHALL never be tracked and SHALL always read as 0.
REQ-003 On id_issue && id_wen && id_wnum != 0, pend[id_wnum] SHALL increment by 1.
REQ-004 On wb_wen && wb_wnum != 0, pend[wb_wnum] SHALL decrement by 1.
REQ-005 An increment and a decrement to the same register in the same cycle SHALL leave the counter unchanged.
REQ-006 A decrement on a counter at 0 SHALL leave it at 0 and set sb_err, which SHALL hold until reset.
REQ-007 Source hazard: src_haz = (id_read_type[0] && pend[id_rs] != 0) || (id_read_type[1] && pend[id_rt] != 0).
- Hazards are evaluated on registered counters.
- A WB in the same cycle does not release the stall until the next cycle.
REQ-008 Destination hazard: dst_haz = id_wen && id_wnum != 0 && pend[id_wnum] == 3 (saturation).
REQ-009 The divider FSM SHALL have three states:
- IDLE: id_issue && id_div -> BUSY, div_cnt loaded with 31.
- BUSY: div_cnt decrements by 1 each cycle; at div_cnt == 0 -> DONE.
- DONE: div_done = 1 for exactly this one cycle -> IDLE.
REQ-010 The divide latency SHALL be 33 cycles from the issue edge to the div_done cycle (32 BUSY cycles + 1 DONE cycle).
REQ-011 HI/LO hazard: hilo_haz = (id_div || id_hilo_rd) && state != IDLE.
- A new divide or a HI/LO read issued in the DONE cycle is stalled.
REQ-012 id_ready SHALL be !src_haz && !dst_haz && !hilo_haz && !flush.
- id_ready is combinational from the current inputs and registered state, with no internal register on the path.
- id_ready is driven even when id_valid = 0; id_issue SHALL be 0 whenever id_valid = 0.
REQ-013 div_busy SHALL be 1 in the BUSY and DONE states.
REQ-014 When flush = 1, the next edge SHALL:
- clear all pend[] counters to 0;
- force the FSM to IDLE with div_cnt = 0 and no div_done pulse;
- leave sb_err unchanged.
- No issue occurs in the flush cycle.
- A wb_wen in the flush cycle is ignored and SHALL NOT set sb_err.
REQ-015 flush SHALL take priority over every simultaneous increment, decrement or FSM transition.

Reset
REQ-016 While resetn = 0, regardless of clk:
- all pend[] = 0, FSM = IDLE, div_cnt = 0, sb_err = 0;
- outputs therefore read div_busy = 0, div_done = 0, id_issue = 0 unless a hazard-free id_valid is present.
REQ-017 Reset deassertion SHALL be synchronized externally; the first edge after release SHALL behave as normal operation.
REQ-018 Reset asserted mid-divide SHALL abort the divide with no div_done pulse.

Verification
REQ-019 Scenario: issue wnum = 5 (wen), next cycle id_rs = 5, read_type = 01 -> id_ready = 0; wb_wen with wb_wnum = 5 -> id_ready = 1 one cycle later.
REQ-020 Scenario: three issues to wnum = 7 with no WB -> pend[7] = 3; a fourth with wnum = 7 -> id_ready = 0 (dst_haz); one WB to 7 -> id_ready = 1 next cycle.
REQ-021 Scenario: issue to wnum = 0 with rs = 0 -> never stalls; wb_wnum = 0 -> sb_err stays 0; WB to 9 with pend[9] = 0 -> sb_err = 1 and held.
REQ-022 Scenario: issue id_div at cycle T -> div_busy = 1 from T+1; div_done = 1 only at T+33; MFHI at T+20 and T+33 stalled; MFHI at T+34 -> id_ready = 1.
REQ-023 Scenario: flush at T+10 of a divide, with pend[3] = 2 and a simultaneous WB to 3 -> at T+11: div_busy = 0, pend[3] = 0, no div_done, sb_err unchanged.
REQ-024 Scenario: simultaneous issue to 4 and WB to 4 with pend[4] = 1 -> pend[4] stays 1; resetn low mid-BUSY -> div_busy = 0 immediately.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue scoreboard for an in-order pipeline.
// Tracks outstanding GPR writes with a 2-bit pending count per register,
// tracks the multi-cycle divider that owns HI/LO, and decides whether the
// instruction held in ID may issue this cycle.
module issue_scoreboard (
  input  logic       clk,
  input  logic       resetn,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_read_type,
  input  logic       id_wen,
  input  logic [4:0] id_wnum,
  input  logic       id_div,
  input  logic       id_hilo_rd,
  input  logic       wb_wen,
  input  logic [4:0] wb_wnum,
  input  logic       flush,
  output logic       id_ready,
  output logic       id_issue,
  output logic       div_busy,
  output logic       div_done,
  output logic       sb_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Entry 0 exists only to keep indexing simple; it is held at zero.
  logic [1:0] pend [0:31];
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [4:0] div_cnt;
  logic [4:0] div_cnt_nxt;

  logic src_haz;
  logic dst_haz;
  logic hilo_haz;
  logic inc;
  logic dec;
  logic underflow;

  // r0 is hard-wired: it never creates a hazard regardless of stored state.
  function automatic logic [1:0] pend_of(input logic [4:0] r);
    logic [1:0] v;
    if (r == 5'd0) begin
      v = 2'd0;
    end else begin
      v = pend[r];
    end
    return v;
  endfunction

  // Hazard detection from registered counters and the current ID contents.
  always_comb begin
    src_haz  = 1'b0;
    dst_haz  = 1'b0;
    hilo_haz = 1'b0;
    if ((id_read_type[0] && (pend_of(id_rs) != 2'd0)) ||
        (id_read_type[1] && (pend_of(id_rt) != 2'd0))) begin
      src_haz = 1'b1;
    end else begin
      src_haz = 1'b0;
    end
    if (id_wen && (id_wnum != 5'd0) && (pend_of(id_wnum) == 2'd3)) begin
      dst_haz = 1'b1;
    end else begin
      dst_haz = 1'b0;
    end
    if ((id_div || id_hilo_rd) && (state != ST_IDLE)) begin
      hilo_haz = 1'b1;
    end else begin
      hilo_haz = 1'b0;
    end
  end

  assign id_ready = !src_haz && !dst_haz && !hilo_haz && !flush;
  assign id_issue = id_valid && id_ready;

  // Counter update requests and the retire-without-pending error condition.
  always_comb begin
    inc = id_issue && id_wen && (id_wnum != 5'd0);
    dec = wb_wen && (wb_wnum != 5'd0);
    if (dec && !flush && (pend_of(wb_wnum) == 2'd0) &&
        !(inc && (id_wnum == wb_wnum))) begin
      underflow = 1'b1;
    end else begin
      underflow = 1'b0;
    end
  end

  // Per-register pending counters; a same-cycle inc and dec cancel out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        pend[i] <= 2'd0;
      end
    end else if (flush) begin
      for (int i = 0; i < 32; i++) begin
        pend[i] <= 2'd0;
      end
    end else begin
      pend[0] <= 2'd0;
      for (int i = 1; i < 32; i++) begin
        case ({inc && (id_wnum == 5'(i)), dec && (wb_wnum == 5'(i))})
          2'b10: begin
            if (pend[i] != 2'd3) begin
              pend[i] <= pend[i] + 2'd1;
            end else begin
              pend[i] <= pend[i];
            end
          end
          2'b01: begin
            if (pend[i] != 2'd0) begin
              pend[i] <= pend[i] - 2'd1;
            end else begin
              pend[i] <= 2'd0;
            end
          end
          default: pend[i] <= pend[i];
        endcase
      end
    end
  end

  // Divider sequencing: 32 BUSY cycles counted down from 31, then one DONE.
  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    case (state)
      ST_IDLE: begin
        if (id_issue && id_div) begin
          state_nxt   = ST_BUSY;
          div_cnt_nxt = 5'd31;
        end else begin
          state_nxt   = ST_IDLE;
          div_cnt_nxt = div_cnt;
        end
      end
      ST_BUSY: begin
        if (div_cnt == 5'd0) begin
          state_nxt   = ST_DONE;
          div_cnt_nxt = 5'd0;
        end else begin
          state_nxt   = ST_BUSY;
          div_cnt_nxt = div_cnt - 5'd1;
        end
      end
      ST_DONE: begin
        state_nxt   = ST_IDLE;
        div_cnt_nxt = 5'd0;
      end
      default: begin
        state_nxt   = ST_IDLE;
        div_cnt_nxt = 5'd0;
      end
    endcase
    if (flush) begin
      state_nxt   = ST_IDLE;
      div_cnt_nxt = 5'd0;
    end else begin
      state_nxt   = state_nxt;
      div_cnt_nxt = div_cnt_nxt;
    end
  end

  // Divider state registers; flush is already folded into the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      div_cnt <= 5'd0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

  // Sticky error flag; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_err <= 1'b0;
    end else if (underflow) begin
      sb_err <= 1'b1;
    end else begin
      sb_err <= sb_err;
    end
  end

  assign div_busy = (state == ST_BUSY) || (state == ST_DONE);
  assign div_done = (state == ST_DONE);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: a cycle-level reference model
// (integer pending counts, a countdown timer for the divide) checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_issue_scoreboard;

  logic       clk;
  logic       resetn;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [1:0] id_read_type;
  logic       id_wen;
  logic [4:0] id_wnum;
  logic       id_div;
  logic       id_hilo_rd;
  logic       wb_wen;
  logic [4:0] wb_wnum;
  logic       flush;
  logic       id_ready;
  logic       id_issue;
  logic       div_busy;
  logic       div_done;
  logic       sb_err;

  issue_scoreboard dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_read_type(id_read_type), .id_wen(id_wen),
    .id_wnum(id_wnum), .id_div(id_div), .id_hilo_rd(id_hilo_rd),
    .wb_wen(wb_wen), .wb_wnum(wb_wnum), .flush(flush),
    .id_ready(id_ready), .id_issue(id_issue), .div_busy(div_busy),
    .div_done(div_done), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference state: outstanding writes per register, cycles left until
  // the divider is idle again (33 after issue, 1 means the done cycle).
  int mp [32];
  int mtimer = 0;
  bit merr = 1'b0;

  function automatic bit exp_ready();
    bit haz;
    haz = flush;
    if (id_read_type[0] && id_rs != 5'd0 && mp[id_rs] > 0) haz = 1'b1;
    if (id_read_type[1] && id_rt != 5'd0 && mp[id_rt] > 0) haz = 1'b1;
    if (id_wen && id_wnum != 5'd0 && mp[id_wnum] >= 3) haz = 1'b1;
    if ((id_div || id_hilo_rd) && mtimer > 0) haz = 1'b1;
    return !haz;
  endfunction

  function automatic int incr(int r);
    return (id_valid && exp_ready() && id_wen && r != 0 && int'(id_wnum) == r) ? 1 : 0;
  endfunction

  function automatic int next_pend(int r);
    int v;
    v = mp[r] + incr(r) - ((wb_wen && r != 0 && int'(wb_wnum) == r) ? 1 : 0);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic bit underflow_now();
    int w;
    w = int'(wb_wnum);
    return wb_wen && w != 0 && (mp[w] + incr(w) - 1 < 0);
  endfunction

  task automatic cmp(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model update, mirroring the clock and async reset.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) mp[r] <= 0;
      mtimer <= 0;
      merr   <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < 32; r++) mp[r] <= 0;
      mtimer <= 0;
    end else begin
      for (int r = 1; r < 32; r++) mp[r] <= next_pend(r);
      if (underflow_now()) merr <= 1'b1;
      if (mtimer > 0) mtimer <= mtimer - 1;
      else if (id_valid && exp_ready() && id_div) mtimer <= 33;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_id_ready", id_ready, exp_ready());
      cmp("m_id_issue", id_issue, id_valid && exp_ready());
      cmp("m_div_busy", div_busy, mtimer > 0);
      cmp("m_div_done", div_done, mtimer == 1);
      cmp("m_sb_err",   sb_err,   merr);
    end
  end

  task automatic idle();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_read_type = 2'b00;
    id_wen = 1'b0; id_wnum = 5'd0; id_div = 1'b0; id_hilo_rd = 1'b0;
    wb_wen = 1'b0; wb_wnum = 5'd0; flush = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] r);
    idle();
    id_valid = 1'b1; id_wen = 1'b1; id_wnum = r;
  endtask

  initial begin
    idle();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1 chk_en = 1'b1;
    nxt(); nxt();
    cmp("rst_div_busy", div_busy, 1'b0);
    cmp("rst_div_done", div_done, 1'b0);
    cmp("rst_sb_err", sb_err, 1'b0);
    cmp("rst_id_ready", id_ready, 1'b1);
    resetn = 1'b1;
    nxt();

    // RAW hazard on r5 released one cycle after its writeback.
    issue_wr(5'd5);
    #1 cmp("raw_first_ready", id_ready, 1'b1);
    nxt();
    idle(); id_valid = 1'b1; id_rs = 5'd5; id_read_type = 2'b01;
    wb_wen = 1'b1; wb_wnum = 5'd5;
    #1 cmp("raw_stall", id_ready, 1'b0);
    nxt();
    wb_wen = 1'b0; wb_wnum = 5'd0;
    #1 cmp("raw_release", id_ready, 1'b1);
    nxt();

    // Destination saturation on r7.
    for (int k = 0; k < 3; k++) begin
      issue_wr(5'd7);
      nxt();
    end
    issue_wr(5'd7); wb_wen = 1'b1; wb_wnum = 5'd7;
    #1 cmp("sat_stall", id_ready, 1'b0);
    nxt();
    wb_wen = 1'b0; wb_wnum = 5'd0;
    #1 cmp("sat_release", id_ready, 1'b1);
    nxt();
    for (int k = 0; k < 3; k++) begin
      idle(); wb_wen = 1'b1; wb_wnum = 5'd7;
      nxt();
    end

    // r0 is never tracked; retiring an unpended register sets sb_err.
    idle(); id_valid = 1'b1; id_wen = 1'b1; id_read_type = 2'b11;
    wb_wen = 1'b1;
    #1 cmp("r0_ready", id_ready, 1'b1);
    nxt();
    idle();
    #1 cmp("r0_no_err", sb_err, 1'b0);
    wb_wen = 1'b1; wb_wnum = 5'd9;
    nxt();
    idle();
    #1 cmp("err_set", sb_err, 1'b1);
    nxt();
    #1 cmp("err_held", sb_err, 1'b1);

    // Divide latency and HI/LO interlock.
    idle(); id_valid = 1'b1; id_div = 1'b1;
    #1 cmp("div_issue_ready", id_ready, 1'b1);
    nxt();
    for (int k = 1; k <= 34; k++) begin
      idle();
      if (k == 20 || k == 33 || k == 34) begin
        id_valid = 1'b1; id_hilo_rd = 1'b1;
      end
      #1;
      cmp("div_done_at_k", div_done, k == 33);
      cmp("div_busy_at_k", div_busy, k <= 33);
      if (id_hilo_rd) cmp("mfhi_ready_at_k", id_ready, k == 34);
      nxt();
    end

    // Flush mid-divide with pending r3 and a concurrent WB to r3.
    issue_wr(5'd3); nxt();
    issue_wr(5'd3); nxt();
    idle(); id_valid = 1'b1; id_div = 1'b1;
    nxt();
    idle();
    repeat (9) nxt();
    flush = 1'b1; wb_wen = 1'b1; wb_wnum = 5'd3;
    #1 cmp("flush_ready", id_ready, 1'b0);
    nxt();
    idle();
    #1;
    cmp("flush_busy", div_busy, 1'b0);
    cmp("flush_done", div_done, 1'b0);
    cmp("flush_err_kept", sb_err, 1'b1);
    id_valid = 1'b1; id_rs = 5'd3; id_read_type = 2'b01;
    #1 cmp("flush_pend_clear", id_ready, 1'b1);
    nxt();
    idle();
    repeat (36) nxt();

    // Simultaneous issue and WB to r4 leave its count at one.
    issue_wr(5'd4); nxt();
    issue_wr(5'd4); wb_wen = 1'b1; wb_wnum = 5'd4;
    #1 cmp("same_reg_ready", id_ready, 1'b1);
    nxt();
    idle(); id_valid = 1'b1; id_rs = 5'd4; id_read_type = 2'b01;
    wb_wen = 1'b1; wb_wnum = 5'd4;
    #1 cmp("same_reg_pend1", id_ready, 1'b0);
    nxt();
    wb_wen = 1'b0; wb_wnum = 5'd0;
    #1 cmp("same_reg_pend0", id_ready, 1'b1);
    nxt();

    // Reset in the middle of a divide aborts it immediately.
    idle(); id_valid = 1'b1; id_div = 1'b1;
    nxt();
    idle();
    repeat (5) nxt();
    cmp("pre_rst_busy", div_busy, 1'b1);
    resetn = 1'b0;
    #1;
    cmp("rst_abort_busy", div_busy, 1'b0);
    cmp("rst_abort_err", sb_err, 1'b0);
    nxt(); nxt();
    resetn = 1'b1;
    repeat (40) nxt();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
